// File: rtl/icache_fill_responder.sv
// I-cache line-fill responder: queues block-address misses, reads each line as MEM_WIDTH beats,
// and returns the assembled line. Define ICFILL_DEDUP_EN to drop strobes already pending or active.
module icache_fill_responder #(
    parameter int ICACHE_TAG_BITS     = 20,
    parameter int ICACHE_INDEX_BITS   = 6,
    parameter int ICACHE_BITS_IN_LINE = 256,
    parameter int MEM_WIDTH           = 64,
    parameter int QUEUE_DEPTH         = 4,
    parameter int PADDR_BITS          = 32
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [ICACHE_TAG_BITS+ICACHE_INDEX_BITS-1:0] ic2memReqAddr_i,
    input  logic                                       ic2memReqValid_i,
    output logic [ICACHE_TAG_BITS-1:0]                 mem2icTag_o,
    output logic [ICACHE_INDEX_BITS-1:0]               mem2icIndex_o,
    output logic [ICACHE_BITS_IN_LINE-1:0]             mem2icData_o,
    output logic                                       mem2icRespValid_o,
    output logic [PADDR_BITS-1:0]                      memReqAddr_o,
    output logic                                       memReqValid_o,
    input  logic                                       memReqReady_i,
    input  logic [MEM_WIDTH-1:0]                       memRespData_i,
    input  logic                                       memRespValid_i,
    output logic                                       reqDropped_o,
    output logic                                       busy_o
);
    localparam int ADDR_W     = ICACHE_TAG_BITS + ICACHE_INDEX_BITS;
    localparam int BEATS      = ICACHE_BITS_IN_LINE / MEM_WIDTH;
    localparam int LINE_BYTES = ICACHE_BITS_IN_LINE / 8;
    localparam int BEAT_BYTES = MEM_WIDTH / 8;
    localparam int PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int CNT_W      = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t                       stateReg, stateNext;
    logic [ADDR_W-1:0]            fifoMem [QUEUE_DEPTH];
    logic [PTR_W-1:0]             headReg, tailReg;
    logic [PTR_W:0]               countReg;
    logic [ADDR_W-1:0]            activeLineReg;
    logic [CNT_W-1:0]             issueCntReg, recvCntReg;
    logic [ICACHE_BITS_IN_LINE-1:0] lineBufReg, lineBufNext;

    logic fifoEmpty, fifoFull, popEn, pushEn, dropEvt, isDup;
    logic captureEn, lastBeat;
    logic [PADDR_BITS-1:0] lineBase, beatOffset;

    assign fifoEmpty = (countReg == '0);
    assign fifoFull  = (countReg == (PTR_W+1)'(QUEUE_DEPTH));

`ifdef ICFILL_DEDUP_EN
    logic [QUEUE_DEPTH-1:0] matchVec;
    logic                   activeHit;

    // Slot gi is live when its distance from head is below the occupancy count.
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] slotDist;
            assign slotDist     = PTR_W'(gi) - headReg;
            assign matchVec[gi] = ({1'b0, slotDist} < countReg) && (fifoMem[gi] == ic2memReqAddr_i);
        end
    endgenerate

    assign activeHit = (stateReg != IDLE) && (activeLineReg == ic2memReqAddr_i);
    assign isDup     = (|matchVec) || activeHit;
`else
    assign isDup = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign pushEn  = ic2memReqValid_i && !isDup && (!fifoFull || popEn);
    assign dropEvt = ic2memReqValid_i && !isDup && fifoFull && !popEn;

    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoMem[tailReg] <= ic2memReqAddr_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
        end else begin
            if (popEn) begin
                headReg <= headReg + 1'b1;
            end
            if (pushEn) begin
                tailReg <= tailReg + 1'b1;
            end
            countReg <= countReg + (PTR_W+1)'(pushEn) - (PTR_W+1)'(popEn);
        end
    end

    assign captureEn = ((stateReg == ISSUE) || (stateReg == DRAIN)) && memRespValid_i
                       && (recvCntReg != CNT_W'(BEATS));
    assign lastBeat  = captureEn && (recvCntReg == CNT_W'(BEATS - 1));

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign lineBufNext[gi*MEM_WIDTH +: MEM_WIDTH] =
                (captureEn && (recvCntReg == CNT_W'(gi))) ? memRespData_i
                                                          : lineBufReg[gi*MEM_WIDTH +: MEM_WIDTH];
        end
    endgenerate

    assign lineBase   = PADDR_BITS'(activeLineReg) * PADDR_BITS'(LINE_BYTES);
    assign beatOffset = PADDR_BITS'(issueCntReg) * PADDR_BITS'(BEAT_BYTES);

    always_comb begin
        stateNext     = stateReg;
        popEn         = 1'b0;
        memReqValid_o = 1'b0;
        memReqAddr_o  = '0;
        case (stateReg)
            IDLE: begin
                if (!fifoEmpty) begin
                    popEn     = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                memReqValid_o = 1'b1;
                memReqAddr_o  = lineBase + beatOffset;
                if (memReqReady_i && (issueCntReg == CNT_W'(BEATS - 1))) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                // The final beat may already have landed while still issuing.
                if (lastBeat || (recvCntReg == CNT_W'(BEATS))) begin
                    stateNext = RESP;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg          <= IDLE;
            activeLineReg     <= '0;
            issueCntReg       <= '0;
            recvCntReg        <= '0;
            lineBufReg        <= '0;
            mem2icTag_o       <= '0;
            mem2icIndex_o     <= '0;
            mem2icData_o      <= '0;
            mem2icRespValid_o <= 1'b0;
            reqDropped_o      <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            lineBufReg <= lineBufNext;
            if (popEn) begin
                activeLineReg <= fifoMem[headReg];
                issueCntReg   <= '0;
                recvCntReg    <= '0;
            end else begin
                if ((stateReg == ISSUE) && memReqReady_i) begin
                    issueCntReg <= issueCntReg + 1'b1;
                end
                if (captureEn) begin
                    recvCntReg <= recvCntReg + 1'b1;
                end
            end
            // Load the response on entry to RESP so the pulse and its payload coincide.
            mem2icRespValid_o <= (stateNext == RESP);
            if ((stateNext == RESP) && (stateReg != RESP)) begin
                mem2icTag_o   <= activeLineReg[ADDR_W-1:ICACHE_INDEX_BITS];
                mem2icIndex_o <= activeLineReg[ICACHE_INDEX_BITS-1:0];
                mem2icData_o  <= lineBufNext;
            end
            if (dropEvt) begin
                reqDropped_o <= 1'b1;
            end
        end
    end

    assign busy_o = (stateReg != IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_icache_fill_responder.sv
// Scoreboard bench for icache_fill_responder: directed fills, stall, queue overflow,
// duplicate strobes (ICFILL_DEDUP_EN aware), stray beats and mid-fill reset.
module tb_icache_fill_responder;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [25:0]  ic2memReqAddr_i = '0;
    logic         ic2memReqValid_i = 1'b0;
    logic [19:0]  mem2icTag_o;
    logic [5:0]   mem2icIndex_o;
    logic [255:0] mem2icData_o;
    logic         mem2icRespValid_o;
    logic [31:0]  memReqAddr_o;
    logic         memReqValid_o;
    logic         memReqReady_i = 1'b1;
    logic [63:0]  memRespData_i = '0;
    logic         memRespValid_i = 1'b0;
    logic         reqDropped_o;
    logic         busy_o;

    icache_fill_responder dut (
        .clk               (clk),
        .reset             (reset),
        .ic2memReqAddr_i   (ic2memReqAddr_i),
        .ic2memReqValid_i  (ic2memReqValid_i),
        .mem2icTag_o       (mem2icTag_o),
        .mem2icIndex_o     (mem2icIndex_o),
        .mem2icData_o      (mem2icData_o),
        .mem2icRespValid_o (mem2icRespValid_o),
        .memReqAddr_o      (memReqAddr_o),
        .memReqValid_o     (memReqValid_o),
        .memReqReady_i     (memReqReady_i),
        .memRespData_i     (memRespData_i),
        .memRespValid_i    (memRespValid_i),
        .reqDropped_o      (reqDropped_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [19:0]  tag;
        logic [5:0]   idx;
        logic [255:0] data;
        int           at;
    } resp_t;
    typedef struct {
        logic [63:0] data;
        int          due;
    } beat_t;

    resp_t       respQ[$];
    logic [31:0] addrQ[$];
    beat_t       memQ[$];

    int memLatency  = 1;
    int stallBeat   = -1;
    int stallLeft   = 0;
    bit injectStray = 1'b0;

    function automatic logic [63:0] beatData(input logic [31:0] a);
        return {~a, a};
    endfunction

    function automatic logic [255:0] lineData(input logic [25:0] l);
        logic [255:0] d;
        for (int k = 0; k < 4; k++) d[k*64 +: 64] = beatData(32'(l) * 32 + 32'(k * 8));
        return d;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [25:0] a);
        ic2memReqAddr_i  = a;
        ic2memReqValid_i = 1'b1;
        nextCycle();
        ic2memReqValid_i = 1'b0;
    endtask

    task automatic expectFill(input logic [25:0] a, input int at, input bit wantResp);
        resp_t r;
        for (int k = 0; k < 4; k++) addrQ.push_back(32'(a) * 32 + 32'(k * 8));
        if (wantResp) begin
            r.tag  = a[25:6];
            r.idx  = a[5:0];
            r.data = lineData(a);
            r.at   = at;
            respQ.push_back(r);
        end
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while ((busy_o || respQ.size() != 0 || memQ.size() != 0) && n < 300) begin
            nextCycle();
            n++;
        end
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL %s: timeout, busy=%0d pending responses=%0d", name, busy_o, respQ.size());
        end
        repeat (3) nextCycle();
    endtask

    // Memory model: optional stall on one beat index, fixed latency, in-order data.
    always begin
        @(posedge clk);
        #2;
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            memRespValid_i = 1'b1;
            memRespData_i  = memQ[0].data;
            memQ.delete(0);
        end else if (injectStray) begin
            memRespValid_i = 1'b1;
            memRespData_i  = 64'hDEAD_BEEF_0BAD_F00D;
            injectStray    = 1'b0;
        end else begin
            memRespValid_i = 1'b0;
            memRespData_i  = '0;
        end
        if (memReqValid_o && stallLeft > 0 && int'(memReqAddr_o[4:3]) == stallBeat) begin
            memReqReady_i = 1'b0;
            stallLeft--;
        end else begin
            memReqReady_i = 1'b1;
        end
        if (memReqValid_o && memReqReady_i) memQ.push_back('{beatData(memReqAddr_o), cyc + memLatency});
    end

    // Monitor: beat addresses, stall stability and line responses against the scoreboard.
    bit          prevStall = 1'b0;
    logic [31:0] prevAddr  = '0;
    always @(negedge clk) begin
        if (reset) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                check("stall_valid_held", 256'(memReqValid_o), 256'(1));
                check("stall_addr_held", 256'(memReqAddr_o), 256'(prevAddr));
            end
            prevStall = memReqValid_o && !memReqReady_i;
            prevAddr  = memReqAddr_o;
            if (memReqValid_o && memReqReady_i) begin
                if (addrQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_addr: got unexpected beat %0h, expected none", memReqAddr_o);
                end else begin
                    check("beat_addr", 256'(memReqAddr_o), 256'(addrQ.pop_front()));
                end
            end
            if (mem2icRespValid_o) begin
                if (respQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp: got unexpected response tag %0h index %0h, expected none",
                             mem2icTag_o, mem2icIndex_o);
                end else begin
                    resp_t e;
                    e = respQ.pop_front();
                    check("resp_tag", 256'(mem2icTag_o), 256'(e.tag));
                    check("resp_index", 256'(mem2icIndex_o), 256'(e.idx));
                    check("resp_data", mem2icData_o, e.data);
                    if (e.at >= 0) check("resp_cycle", 256'(cyc), 256'(e.at));
                    $display("[TB] response tag=%0h index=%0h cycle=%0d", mem2icTag_o, mem2icIndex_o, cyc);
                end
            end
        end
    end

    initial begin
        int t0;
        resp_t r;
        #1 reset = 1'b1;
        repeat (3) nextCycle();
        check("rst_resp_valid", 256'(mem2icRespValid_o), 256'(0));
        check("rst_req_valid", 256'(memReqValid_o), 256'(0));
        check("rst_req_addr", 256'(memReqAddr_o), 256'(0));
        check("rst_busy", 256'(busy_o), 256'(0));
        check("rst_dropped", 256'(reqDropped_o), 256'(0));
        check("rst_data", mem2icData_o, 256'(0));
        reset = 1'b0;
        nextCycle();

        // Single miss, 1-cycle memory latency
        t0 = cyc;
        addrQ.push_back(32'h0002_4680);
        addrQ.push_back(32'h0002_4688);
        addrQ.push_back(32'h0002_4690);
        addrQ.push_back(32'h0002_4698);
        r.tag = 20'h48; r.idx = 6'h34; r.data = lineData(26'h1234); r.at = t0 + 7;
        respQ.push_back(r);
        strobe(26'h1234);
        waitDone("single_miss");

        // Ready low for 3 cycles on beat 1 delays the response by 3
        stallBeat = 1;
        stallLeft = 3;
        t0 = cyc;
        expectFill(26'h0ABCD, t0 + 10, 1'b1);
        strobe(26'h0ABCD);
        waitDone("stall_fill");
        stallBeat = -1;

        // Stray beat while idle leaves the held response untouched
        injectStray = 1'b1;
        repeat (5) nextCycle();
        check("stray_data_hold", mem2icData_o, lineData(26'h0ABCD));
        check("stray_busy", 256'(busy_o), 256'(0));

        // Duplicate strobe while the same line is active
        expectFill(26'h40, -1, 1'b1);
        strobe(26'h40);
        repeat (2) nextCycle();
`ifndef ICFILL_DEDUP_EN
        expectFill(26'h40, -1, 1'b1);
`endif
        strobe(26'h40);
        waitDone("dup_fill");
        check("dup_no_drop", 256'(reqDropped_o), 256'(0));

        // Five back-to-back strobes fit; a sixth overflows
        for (int i = 0; i < 5; i++) expectFill(26'h100 + 26'(i), -1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("drop_before_overflow", 256'(reqDropped_o), 256'(0));
            ic2memReqAddr_i  = 26'h100 + 26'(i);
            ic2memReqValid_i = 1'b1;
            nextCycle();
        end
        ic2memReqValid_i = 1'b0;
        check("drop_after_overflow", 256'(reqDropped_o), 256'(1));
        waitDone("queue_fill");
        check("drop_sticky", 256'(reqDropped_o), 256'(1));

        // Reset in DRAIN with 2 of 4 beats received (latency 3)
        memLatency = 3;
        expectFill(26'h2A5, -1, 1'b0);
        strobe(26'h2A5);
        repeat (6) nextCycle();
        reset = 1'b1;
        #1;
        check("midrst_resp_valid", 256'(mem2icRespValid_o), 256'(0));
        check("midrst_req_valid", 256'(memReqValid_o), 256'(0));
        check("midrst_busy", 256'(busy_o), 256'(0));
        check("midrst_dropped", 256'(reqDropped_o), 256'(0));
        check("midrst_tag", 256'(mem2icTag_o), 256'(0));
        check("midrst_data", mem2icData_o, 256'(0));
        nextCycle();
        reset = 1'b0;
        repeat (10) nextCycle();
        check("midrst_beats_issued", 256'(addrQ.size()), 256'(0));
        check("midrst_idle", 256'(busy_o), 256'(0));
        memLatency = 1;

        // Recovery fill at the top of the address space
        t0 = cyc;
        expectFill(26'h3FF_FFFF, t0 + 7, 1'b1);
        strobe(26'h3FF_FFFF);
        waitDone("max_addr_fill");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
